// File: rtl/l1_l2_rr_scheduler.sv
// l1_l2_rr_scheduler: shares the single L2 request port between the icache
// miss path and the dcache miss/writeback path. Round-robin arbitration,
// one outstanding L2 transaction at a time, request fields captured at grant
// and held until the L2 response is routed back to the owner.
// Build macro MEM_ARB_TIMEOUT_EN adds a per-transaction watchdog that
// completes a stuck transaction with an error response.
module l1_l2_rr_scheduler #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req_valid,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic            i_req_write,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_req_size,
    input  logic            d_req_valid,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic            d_req_write,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [1:0]      d_req_size,
    output logic            i_rsp_valid,
    output logic [XLEN-1:0] i_rsp_rdata,
    output logic            i_rsp_err,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rsp_rdata,
    output logic            d_rsp_err,
    output logic            l2_req_valid,
    output logic [XLEN-1:0] l2_req_addr,
    output logic            l2_req_write,
    output logic [XLEN-1:0] l2_req_wdata,
    output logic [1:0]      l2_req_size,
    input  logic            l2_rsp_valid,
    input  logic [XLEN-1:0] l2_rsp_rdata,
    output logic            owner,
    output logic            busy,
    output logic            timeout_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            last_grant_reg, last_grant_next;  // 0 = icache, 1 = dcache
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            write_reg;
    logic [1:0]      size_reg;

    logic            in_busy;
    logic            grant_i;
    logic            grant_d;
    logic            timeout_hit;
    logic            done;

    assign in_busy = (state_reg != IDLE);
    // On a tie the requester that did not win last time gets the grant.
    assign grant_i = i_req_valid && (!d_req_valid || last_grant_reg);
    assign grant_d = d_req_valid && (!i_req_valid || !last_grant_reg);
    assign done    = in_busy && (l2_rsp_valid || timeout_hit);

    // Next-state and arbitration decision.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (grant_i) begin
                    state_next      = BUSY_I;
                    last_grant_next = 1'b0;
                end else if (grant_d) begin
                    state_next      = BUSY_D;
                    last_grant_next = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and round-robin pointer; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Capture the winning request at grant; held stable for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            size_reg  <= 2'd0;
        end else if (state_reg == IDLE && (grant_i || grant_d)) begin
            addr_reg  <= grant_i ? i_req_addr  : d_req_addr;
            wdata_reg <= grant_i ? i_req_wdata : d_req_wdata;
            write_reg <= grant_i ? i_req_write : d_req_write;
            size_reg  <= grant_i ? i_req_size  : d_req_size;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             flag_reg;

    assign timeout_hit  = in_busy && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_flag = flag_reg;

    // Watchdog counter: zero on entry to BUSY, counts every BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (!in_busy) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Sticky flag; a response arriving on the timeout cycle is not a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_reg <= 1'b0;
        end else if (timeout_hit && !l2_rsp_valid) begin
            flag_reg <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_flag       = 1'b0;
`endif

    assign l2_req_valid = in_busy;
    assign l2_req_addr  = addr_reg;
    assign l2_req_write = write_reg;
    assign l2_req_wdata = wdata_reg;
    assign l2_req_size  = size_reg;
    assign busy         = in_busy;
    assign owner        = (state_reg == BUSY_D);

    // Route the completion to the owner in the same cycle; data is zero otherwise.
    always_comb begin
        i_rsp_valid = 1'b0;
        i_rsp_rdata = '0;
        i_rsp_err   = 1'b0;
        d_rsp_valid = 1'b0;
        d_rsp_rdata = '0;
        d_rsp_err   = 1'b0;
        if (done) begin
            if (state_reg == BUSY_I) begin
                i_rsp_valid = 1'b1;
                i_rsp_rdata = l2_rsp_valid ? l2_rsp_rdata : '0;
                i_rsp_err   = !l2_rsp_valid;
            end else begin
                d_rsp_valid = 1'b1;
                d_rsp_rdata = l2_rsp_valid ? l2_rsp_rdata : '0;
                d_rsp_err   = !l2_rsp_valid;
            end
        end
    end

endmodule

// File: tb/tb_l1_l2_rr_scheduler.sv
// Testbench for l1_l2_rr_scheduler: directed scenarios followed by a
// randomized phase checked against a transaction-level reference model.
// The watchdog scenario is included when MEM_ARB_TIMEOUT_EN is defined.
module tb_l1_l2_rr_scheduler;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_req_valid, i_req_write, d_req_valid, d_req_write;
    logic [XLEN-1:0] i_req_addr, i_req_wdata, d_req_addr, d_req_wdata;
    logic [1:0]      i_req_size, d_req_size;
    logic            i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err;
    logic [XLEN-1:0] i_rsp_rdata, d_rsp_rdata;
    logic            l2_req_valid, l2_req_write;
    logic [XLEN-1:0] l2_req_addr, l2_req_wdata;
    logic [1:0]      l2_req_size;
    logic            l2_rsp_valid;
    logic [XLEN-1:0] l2_rsp_rdata;
    logic            owner, busy, timeout_flag;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (transaction level)
    bit              m_busy, m_owner, m_last;
    int              m_age;
    logic [XLEN-1:0] m_addr, m_wdata;
    logic            m_write;
    logic [1:0]      m_size;
    bit              r_pend  [2];
    logic [XLEN-1:0] r_addr  [2];
    logic [XLEN-1:0] r_wdata [2];
    logic            r_write [2];
    logic [1:0]      r_size  [2];

    l1_l2_rr_scheduler #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_write(l2_req_write),
        .l2_req_wdata(l2_req_wdata), .l2_req_size(l2_req_size),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_rdata(l2_rsp_rdata),
        .owner(owner), .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_valid = 0; i_req_addr = '0; i_req_write = 0; i_req_wdata = '0; i_req_size = 2'd0;
        d_req_valid = 0; d_req_addr = '0; d_req_write = 0; d_req_wdata = '0; d_req_size = 2'd0;
        l2_rsp_valid = 0; l2_rsp_rdata = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        check("rst_l2_valid", l2_req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_i_rsp", i_rsp_valid, 0);
        check("rst_d_rsp", d_rsp_valid, 0);
        check("rst_l2_addr", l2_req_addr, 0);
        check("rst_tflag", timeout_flag, 0);

        // Single icache read, response three cycles into the transaction
        tick();
        i_req_valid = 1; i_req_addr = 32'h100; i_req_size = 2'd2; i_req_write = 0;
        @(negedge clk);
        check("t1_no_same_cycle", l2_req_valid, 0);
        tick(); @(negedge clk);
        check("t1_l2_valid", l2_req_valid, 1);
        check("t1_l2_addr", l2_req_addr, 32'h100);
        check("t1_l2_size", l2_req_size, 2);
        check("t1_l2_write", l2_req_write, 0);
        check("t1_owner", owner, 0);
        tick(); @(negedge clk);
        check("t1_hold_valid", l2_req_valid, 1);
        check("t1_no_early_rsp", i_rsp_valid, 0);
        tick();
        l2_rsp_valid = 1; l2_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_i_rsp", i_rsp_valid, 1);
        check("t1_i_rdata", i_rsp_rdata, 32'hDEADBEEF);
        check("t1_i_err", i_rsp_err, 0);
        check("t1_d_rsp", d_rsp_valid, 0);
        check("t1_d_rdata", d_rsp_rdata, 0);
        tick();
        l2_rsp_valid = 0; l2_rsp_rdata = '0; i_req_valid = 0;
        @(negedge clk);
        check("t1_l2_drop", l2_req_valid, 0);
        check("t1_rsp_gone", i_rsp_valid, 0);
        $display("txn t1: icache read 0x100 -> 0xDEADBEEF");

        // Continuous contention from reset: I, D, I, D with idle gaps
        tick(); reset = 1;
        tick(); reset = 0;
        i_req_valid = 1; i_req_addr = 32'h1000; i_req_size = 2'd2; i_req_write = 0;
        d_req_valid = 1; d_req_addr = 32'h2000; d_req_size = 2'd1; d_req_write = 1; d_req_wdata = 32'h77;
        @(negedge clk);
        check("t2_idle_first", busy, 0);
        for (int t = 0; t < 4; t++) begin
            logic exp_own;
            exp_own = t[0];
            tick();
            l2_rsp_valid = 1; l2_rsp_rdata = 32'hA000 + t;
            @(negedge clk);
            check("t2_owner", owner, exp_own);
            check("t2_l2_valid", l2_req_valid, 1);
            check("t2_l2_addr", l2_req_addr, exp_own ? 32'h2000 : 32'h1000);
            check("t2_i_rsp", i_rsp_valid, !exp_own);
            check("t2_d_rsp", d_rsp_valid, exp_own);
            tick();
            l2_rsp_valid = 0;
            if (t == 3) begin
                i_req_valid = 0; d_req_valid = 0;
            end
            @(negedge clk);
            check("t2_gap", l2_req_valid, 0);
            $display("txn t2.%0d: grant %s", t, exp_own ? "D" : "I");
        end

        // dcache byte store; requester fields change and valid drops mid-flight
        tick();
        d_req_valid = 1; d_req_addr = 32'h204; d_req_wdata = 32'h55; d_req_size = 2'd0; d_req_write = 1;
        @(negedge clk);
        tick();
        d_req_addr = 32'h300; d_req_wdata = 32'hAA; d_req_size = 2'd2;
        @(negedge clk);
        check("t3_owner", owner, 1);
        check("t3_addr", l2_req_addr, 32'h204);
        check("t3_size", l2_req_size, 0);
        check("t3_write", l2_req_write, 1);
        check("t3_wdata", l2_req_wdata, 32'h55);
        tick();
        d_req_valid = 0;
        @(negedge clk);
        check("t3_abort_hold", l2_req_valid, 1);
        check("t3_abort_addr", l2_req_addr, 32'h204);
        tick();
        l2_rsp_valid = 1; l2_rsp_rdata = 32'h12345678;
        @(negedge clk);
        check("t3_d_rsp", d_rsp_valid, 1);
        check("t3_d_rdata", d_rsp_rdata, 32'h12345678);
        check("t3_i_rsp", i_rsp_valid, 0);
        tick();
        l2_rsp_valid = 0;
        @(negedge clk);
        check("t3_done", l2_req_valid, 0);
        $display("txn t3: dcache byte store 0x204 (aborted requester) completed");

        // Reset in the middle of a dcache transaction
        tick();
        d_req_valid = 1; d_req_addr = 32'h400; d_req_size = 2'd2; d_req_write = 0;
        @(negedge clk);
        tick();
        i_req_valid = 1; i_req_addr = 32'h500; i_req_size = 2'd2;
        @(negedge clk);
        check("t4_busy_d", owner, 1);
        check("t4_pre_valid", l2_req_valid, 1);
        #1 reset = 1;
        #1;
        check("t4_async_drop", l2_req_valid, 0);
        check("t4_async_busy", busy, 0);
        l2_rsp_valid = 1; l2_rsp_rdata = 32'h99;
        #1;
        check("t4_no_d_rsp", d_rsp_valid, 0);
        check("t4_no_i_rsp", i_rsp_valid, 0);
        tick();
        l2_rsp_valid = 0; reset = 0;
        @(negedge clk);
        check("t4_idle_after", l2_req_valid, 0);
        tick(); @(negedge clk);
        check("t4_i_wins_tie", owner, 0);
        check("t4_i_addr", l2_req_addr, 32'h500);
        tick();
        l2_rsp_valid = 1; l2_rsp_rdata = 32'h1;
        @(negedge clk);
        check("t4_i_rsp", i_rsp_valid, 1);
        tick();
        l2_rsp_valid = 0; i_req_valid = 0; d_req_valid = 0;
        @(negedge clk);
        $display("txn t4: reset mid BUSY_D, icache won first tie");

        // Spurious L2 response while idle
        tick();
        l2_rsp_valid = 1; l2_rsp_rdata = 32'hFFFF;
        @(negedge clk);
        check("t5_i_rsp", i_rsp_valid, 0);
        check("t5_d_rsp", d_rsp_valid, 0);
        check("t5_i_rdata", i_rsp_rdata, 0);
        check("t5_d_rdata", d_rsp_rdata, 0);
        tick();
        l2_rsp_valid = 0;
        @(negedge clk);
        check("t5_still_idle", busy, 0);
        $display("txn t5: spurious l2 response ignored");

        // Randomized traffic against the reference model
        tick(); reset = 1; clear_inputs();
        tick(); reset = 0;
        for (int k = 0; k < 2; k++) r_pend[k] = 0;
        m_busy = 0; m_last = 1; m_age = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic exp_i, exp_d;
            for (int k = 0; k < 2; k++) begin
                if (!r_pend[k] && $urandom_range(0, 2) == 0) begin
                    r_pend[k]  = 1;
                    r_addr[k]  = $urandom;
                    r_wdata[k] = $urandom;
                    r_write[k] = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    r_size[k]  = 2'($urandom_range(0, 2));
                end
            end
            i_req_valid = r_pend[0]; i_req_addr = r_addr[0]; i_req_wdata = r_wdata[0];
            i_req_write = r_write[0]; i_req_size = r_size[0];
            d_req_valid = r_pend[1]; d_req_addr = r_addr[1]; d_req_wdata = r_wdata[1];
            d_req_write = r_write[1]; d_req_size = r_size[1];
            if (m_busy && $urandom_range(0, 1) == 1) begin
                if (!m_owner) begin
                    i_req_addr = $urandom; i_req_size = 2'($urandom_range(0, 2));
                    if ($urandom_range(0, 3) == 0) i_req_valid = 0;
                end else begin
                    d_req_addr = $urandom; d_req_wdata = $urandom; d_req_write = ~d_req_write;
                    if ($urandom_range(0, 3) == 0) d_req_valid = 0;
                end
            end
            l2_rsp_valid = m_busy ? (m_age >= 6 || $urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 7) == 0);
            l2_rsp_rdata = $urandom;
            @(negedge clk);
            exp_i = m_busy && !m_owner && l2_rsp_valid;
            exp_d = m_busy && m_owner && l2_rsp_valid;
            check("rnd_busy", busy, m_busy);
            check("rnd_l2_valid", l2_req_valid, m_busy);
            if (m_busy) begin
                check("rnd_owner", owner, m_owner);
                check("rnd_addr", l2_req_addr, m_addr);
                check("rnd_wdata", l2_req_wdata, m_wdata);
                check("rnd_write", l2_req_write, m_write);
                check("rnd_size", l2_req_size, m_size);
            end
            check("rnd_i_rsp", i_rsp_valid, exp_i);
            check("rnd_d_rsp", d_rsp_valid, exp_d);
            check("rnd_i_rdata", i_rsp_rdata, exp_i ? l2_rsp_rdata : '0);
            check("rnd_d_rdata", d_rsp_rdata, exp_d ? l2_rsp_rdata : '0);
            check("rnd_i_err", i_rsp_err, 0);
            check("rnd_d_err", d_rsp_err, 0);
            if (exp_i || exp_d)
                $display("txn rnd cyc %0d: %s response 0x%0h", cyc, exp_d ? "D" : "I", l2_rsp_rdata);
            // Advance model: completion frees the port, otherwise arbitrate while idle
            if (m_busy) begin
                if (l2_rsp_valid) begin
                    m_busy = 0;
                    r_pend[m_owner] = 0;
                end else begin
                    m_age++;
                end
            end else if (r_pend[0] || r_pend[1]) begin
                m_owner = (r_pend[0] && r_pend[1]) ? !m_last : r_pend[1];
                m_last  = m_owner;
                m_busy  = 1;
                m_age   = 0;
                m_addr  = r_addr[m_owner];
                m_wdata = r_wdata[m_owner];
                m_write = r_write[m_owner];
                m_size  = r_size[m_owner];
            end
            tick();
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: silent L2 produces an error response after 8 busy cycles
        reset = 1; clear_inputs();
        tick(); reset = 0;
        @(negedge clk);
        check("to_flag_clear", timeout_flag, 0);
        tick();
        i_req_valid = 1; i_req_addr = 32'h600; i_req_size = 2'd2;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            tick(); @(negedge clk);
            check("to_wait_no_rsp", i_rsp_valid, 0);
            check("to_wait_valid", l2_req_valid, 1);
        end
        tick(); @(negedge clk);
        check("to_i_rsp", i_rsp_valid, 1);
        check("to_i_err", i_rsp_err, 1);
        check("to_i_rdata", i_rsp_rdata, 0);
        check("to_d_rsp", d_rsp_valid, 0);
        tick();
        i_req_valid = 0;
        @(negedge clk);
        check("to_l2_drop", l2_req_valid, 0);
        check("to_flag_set", timeout_flag, 1);
        tick();
        d_req_valid = 1; d_req_addr = 32'h700; d_req_size = 2'd2;
        @(negedge clk);
        tick();
        l2_rsp_valid = 1; l2_rsp_rdata = 32'h4242;
        @(negedge clk);
        check("to_next_rsp", d_rsp_valid, 1);
        check("to_next_err", d_rsp_err, 0);
        check("to_next_rdata", d_rsp_rdata, 32'h4242);
        check("to_flag_sticky", timeout_flag, 1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("to_next_done", l2_req_valid, 0);
        $display("txn to: watchdog error response, next request normal");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l1_l2_rr_scheduler.md
Name: l1_l2_rr_scheduler

Overview:
- Shares the single L2 request port between the icache miss path and the dcache miss/writeback path.
- Round-robin arbitration with per-transaction lock: one outstanding L2 transaction at a time.
- Captures the winning request, holds it stable on the L2 side until the response returns, then routes the response to the owner.
- Carries the real access size to L2 instead of a constant WORD.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req_valid / d_req_valid  in  1  request pending; held high until the matching rsp_valid.
- i_req_addr / d_req_addr  in  XLEN  byte address.
- i_req_write / d_req_write  in  1  1=store; icache drives 0.
- i_req_wdata / d_req_wdata  in  XLEN  store data.
- i_req_size / d_req_size  in  2  BYTE=0, HALF=1, WORD=2.
- i_rsp_valid / d_rsp_valid  out  1  single-cycle response pulse.
- i_rsp_rdata / d_rsp_rdata  out  XLEN  read data, valid with rsp_valid.
- i_rsp_err / d_rsp_err  out  1  timeout error, valid with rsp_valid.
- l2_req_valid  out  1  L2 request.
- l2_req_addr, l2_req_write, l2_req_wdata, l2_req_size  out  XLEN/1/XLEN/2  captured request fields.
- l2_rsp_valid  in  1  L2 completion pulse.
- l2_rsp_rdata  in  XLEN  L2 read data.
- owner  out  1  0=icache, 1=dcache; meaningful while busy.
- busy  out  1  transaction in flight.
- timeout_flag  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset values:
  - State IDLE.
  - last_grant=D, so icache wins the first tie.
  - All outputs 0.
  - Reset takes effect asynchronously, including l2_req_valid.
- IDLE, arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - On grant: register addr/write/wdata/size, update last_grant, go to BUSY_x.
- Request latency: a request sampled in cycle N gives l2_req_valid=1 in cycle N+1.
- BUSY_x:
  - l2_req_valid=1 and fields stay constant.
  - Requester field changes and deassertion are ignored.
- Completion:
  - l2_rsp_valid in BUSY_x drives x_rsp_valid=1 in the same cycle, combinationally.
  - x_rsp_rdata = l2_rsp_rdata; other requester's rsp_valid=0.
  - Next state IDLE; l2_req_valid=0 in the following cycle.
- Requester rule: drop req_valid, or present a new request, in the cycle after rsp_valid. The IDLE cycle guarantees a minimum 1-cycle gap between L2 transactions.
- Aborted request: if the owner drops req_valid mid-flight, the transaction still completes and the response pulse is still issued.
- l2_rsp_valid in IDLE is ignored; no response is forwarded.
- Fairness: under continuous contention, grants alternate I, D, I, D.
- Reset mid-transaction:
  - The in-flight transaction is dropped; no response is issued.
  - The requester reissues after reset deasserts.
- rsp_rdata outputs are 0 whenever the matching rsp_valid=0.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to BUSY_x and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no l2_rsp_valid: x_rsp_valid=1, x_rsp_err=1, x_rsp_rdata=0, l2_req_valid drops next cycle, state returns to IDLE, timeout_flag set until reset.
  - If l2_rsp_valid and the timeout coincide, the normal response wins (err=0).
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter.
  - rsp_err and timeout_flag tied 0.
  - BUSY waits indefinitely.

Test Plan:
- i_req_valid alone, addr=0x100, size=WORD; L2 responds 3 cycles after grant with 0xDEADBEEF -> l2_req_valid at cycle+1, addr 0x100, size=2; i_rsp_valid pulse with 0xDEADBEEF; d_rsp_valid stays 0.
- Both requesters valid from reset -> grant order I, D, I, D over 4 transactions; owner toggles; one idle cycle between L2 requests.
- d store addr=0x204, wdata=0x55, size=BYTE; dcache changes addr to 0x300 while busy -> l2_req_addr stays 0x204, size=0, write=1 until l2_rsp_valid.
- Reset asserted mid-BUSY_D -> l2_req_valid falls immediately; no d_rsp_valid; after release, a pending i request wins the first tie.
- Spurious l2_rsp_valid in IDLE -> no rsp pulses; state stays IDLE.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, L2 silent -> i_rsp_valid=1, i_rsp_err=1 exactly 8 busy cycles after grant; timeout_flag=1 until reset; the next request proceeds normally.
